// File: rtl/icache_refill_ctrl.sv
// Refill engine for the direct-mapped I-cache: fetches one block word by word
// over a single-outstanding memory port and returns each word as a one-cycle beat.
module icache_refill_ctrl #(
  parameter int          WORDSPERBLOCK  = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] FILL_WORD      = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        miss,
  input  logic [31:0] fetchaddr,
  output logic [31:0] ifetch,
  output logic        iready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        bus_err
);

  localparam int          WB         = $clog2(WORDSPERBLOCK);
  localparam int          OFFSETBITS = 2 + WB;
  localparam int          TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0] BLOCK_MASK = ~((32'd1 << OFFSETBITS) - 32'd1);
  localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [WB:0]   CNT_LAST = (WB + 1)'(WORDSPERBLOCK - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, COOL} state_t;

  state_t      state, state_nxt;
  logic [WB:0] word_cnt;
  logic [WB:0] cnt_inc;
  logic [TW-1:0] timer;
  logic [31:0] base;
  logic [31:0] next_addr;
  logic        timeout;
  logic        word_done;
  logic        last_word;

  assign cnt_inc   = word_cnt + (WB + 1)'(1);
  assign next_addr = base + {{(29 - WB){1'b0}}, cnt_inc, 2'b00};
  assign timeout   = (timer == TLAST);
  assign word_done = (state == REQ) && (mem_rvalid || timeout);
  assign last_word = (word_cnt == CNT_LAST);

  assign busy    = (state != IDLE);
  assign mem_req = (state == REQ);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (miss) state_nxt = REQ;
      REQ:  if (word_done) state_nxt = last_word ? COOL : GAP;
      GAP:  state_nxt = REQ;
      // miss is still high here because the cache drops it a cycle after the last beat
      COOL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
      timer    <= '0;
      base     <= '0;
      mem_addr <= '0;
      ifetch   <= '0;
      iready   <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      iready <= 1'b0;
      case (state)
        IDLE: begin
          if (miss) begin
            base     <= fetchaddr & BLOCK_MASK;
            mem_addr <= fetchaddr & BLOCK_MASK;
            word_cnt <= '0;
            timer    <= '0;
          end
        end
        REQ: begin
          timer <= timer + TW'(1);
          // a response arriving on the timeout cycle still counts as real data
          if (mem_rvalid) begin
            ifetch   <= mem_rdata;
            iready   <= 1'b1;
            word_cnt <= cnt_inc;
            mem_addr <= next_addr;
          end else if (timeout) begin
            ifetch   <= FILL_WORD;
            iready   <= 1'b1;
            bus_err  <= 1'b1;
            word_cnt <= cnt_inc;
            mem_addr <= next_addr;
          end
        end
        GAP: timer <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a latency-programmable memory model.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss;
  logic [31:0] fetchaddr;
  logic [31:0] ifetch;
  logic        iready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        bus_err;

  int total = 0;
  int bad = 0;

  int          lat_tab [4];
  logic [31:0] beats[$];
  logic [31:0] req_addrs[$];
  int          req_len[$];
  int          gaps[$];
  int          seq_err;
  int          hi_run, low_run, cnt;
  logic        prev_iready, prev_req, prev_rvalid;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk(clk), .reset(reset), .miss(miss), .fetchaddr(fetchaddr),
    .ifetch(ifetch), .iready(iready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .bus_err(bus_err)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  // Monitor first (sees values driven before this edge), then the memory responder.
  initial begin
    seq_err = 0; hi_run = 0; low_run = 0; cnt = 0;
    prev_iready = 1'b0; prev_req = 1'b0; prev_rvalid = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (iready) begin
        beats.push_back(ifetch);
        if (prev_iready || !prev_req) seq_err++;
      end else if (prev_req && prev_rvalid && !reset) begin
        seq_err++;
      end
      if (mem_req) begin
        if (!prev_req) begin
          req_addrs.push_back(mem_addr);
          if (low_run > 0) gaps.push_back(low_run);
          hi_run = 0;
        end
        hi_run++;
        low_run = 0;
      end else begin
        if (prev_req) req_len.push_back(hi_run);
        if (busy) low_run++;
        else      low_run = 0;
      end
      prev_iready = iready;
      prev_req    = mem_req;
      if (mem_req) begin
        cnt++;
        if (cnt == lat_tab[(mem_addr >> 2) & 32'd3]) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mdata(mem_addr);
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = 32'hDEADBEEF;
        end
      end else begin
        cnt = 0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEADBEEF;
      end
      prev_rvalid = mem_rvalid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    beats.delete(); req_addrs.delete(); req_len.delete(); gaps.delete();
    seq_err = 0;
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat_tab[0] = l0; lat_tab[1] = l1; lat_tab[2] = l2; lat_tab[3] = l3;
  endtask

  // Full refill with miss held through the beat after COOL, as the cache does.
  task automatic refill(input string tag, input logic [31:0] addr);
    int n;
    clear_logs();
    @(negedge clk);
    chk({tag, "_req_before"}, {31'b0, mem_req}, 32'd0);
    miss = 1'b1;
    fetchaddr = addr;
    @(posedge clk); #1;
    chk({tag, "_req_rise"}, {31'b0, mem_req}, 32'd1);
    chk({tag, "_busy_rise"}, {31'b0, busy}, 32'd1);
    fetchaddr = addr + 32'd4;
    n = 0;
    while (beats.size() < 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_beats_in_time"}, {31'b0, n < 3000}, 32'd1);
    @(negedge clk);
    miss = 1'b0;
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk({tag, "_beat_count"}, beats.size(), 32'd4);
    chk({tag, "_req_count"}, req_addrs.size(), 32'd4);
    chk({tag, "_gap_count"}, gaps.size(), 32'd3);
    chk({tag, "_seq_err"}, seq_err, 32'd0);
    for (int i = 0; i < gaps.size(); i++) chk({tag, "_gap"}, gaps[i], 32'd1);
  endtask

  task automatic chk_block(input string tag, input logic [31:0] base, input int skip);
    for (int i = 0; i < req_addrs.size(); i++)
      chk({tag, "_addr"}, req_addrs[i], base + 32'(4 * i));
    for (int i = 0; i < beats.size(); i++)
      if (i != skip) chk({tag, "_data"}, beats[i], mdata(base + 32'(4 * i)));
  endtask

  initial begin
    int n;
    reset = 1'b1; miss = 1'b0; fetchaddr = '0;
    set_lat(1, 1, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iready", {31'b0, iready}, 32'd0);
    chk("rst_ifetch", ifetch, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, bus_err}, 32'd0);
    reset = 1'b0;

    // 1: single-cycle memory
    refill("t1", 32'h00001234);
    chk_block("t1", 32'h00001230, -1);
    for (int i = 0; i < req_len.size(); i++) chk("t1_reqlen", req_len[i], 32'd1);
    chk("t1_err", {31'b0, bus_err}, 32'd0);

    // 2: five-cycle memory
    set_lat(5, 5, 5, 5);
    refill("t2", 32'h0000200C);
    chk_block("t2", 32'h00002000, -1);
    for (int i = 0; i < req_len.size(); i++) chk("t2_reqlen", req_len[i], 32'd5);

    // 3: second word never answers
    set_lat(1, 1000, 1, 1);
    refill("t3", 32'h00003000);
    chk_block("t3", 32'h00003000, 1);
    if (beats.size() > 1) chk("t3_fill", beats[1], 32'h00000013);
    if (req_len.size() > 1) chk("t3_reqlen_to", req_len[1], 32'd64);
    chk("t3_err_idle", {31'b0, bus_err}, 32'd1);
    repeat (5) @(negedge clk);
    chk("t3_err_sticky", {31'b0, bus_err}, 32'd1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("err_cleared", {31'b0, bus_err}, 32'd0);

    // 4: response on the last allowed cycle
    set_lat(64, 1, 1, 1);
    refill("t4", 32'h00004000);
    chk_block("t4", 32'h00004000, -1);
    if (req_len.size() > 0) chk("t4_reqlen", req_len[0], 32'd64);
    chk("t4_err", {31'b0, bus_err}, 32'd0);

    // 5: top of address space
    set_lat(1, 1, 1, 1);
    refill("t5", 32'hFFFFFFF8);
    chk_block("t5", 32'hFFFFFFF0, -1);

    // 6: reset during the second word's request
    set_lat(1, 10, 1, 1);
    clear_logs();
    @(negedge clk);
    miss = 1'b1;
    fetchaddr = 32'h00005000;
    n = 0;
    while (req_addrs.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_w1", {31'b0, n < 100}, 32'd1);
    chk("t6_w1_addr", mem_addr, 32'h00005004);
    reset = 1'b1;
    miss = 1'b0;
    @(posedge clk); #1;
    chk("t6_req", {31'b0, mem_req}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_iready", {31'b0, iready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_beats_aborted", beats.size(), 32'd1);
    chk("t6_no_req", {31'b0, mem_req}, 32'd0);
    refill("t6b", 32'h00005000);
    chk_block("t6b", 32'h00005000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
